// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 access sizes and LSU FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication/strobes, misalignment flag,
// and load lane extraction with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  acc_funct3,
  input  logic [1:0]  acc_addr_lo,
  input  logic [31:0] acc_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  // funct3[1:0] carries the size for both signed and unsigned variants
  always_comb begin
    st_wdata   = acc_data;
    st_wstrb   = 4'b1111;
    misaligned = 1'b0;
    case (acc_funct3[1:0])
      2'b00: begin
        st_wdata = {4{acc_data[7:0]}};
        st_wstrb = 4'b0001 << acc_addr_lo;
      end
      2'b01: begin
        st_wdata   = {2{acc_data[15:0]}};
        st_wstrb   = 4'b0011 << acc_addr_lo;
        misaligned = acc_addr_lo[0];
      end
      default: misaligned = |acc_addr_lo;
    endcase
  end

  assign ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = ld_shifted;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_BU:   ld_data = {24'h0, ld_shifted[7:0]};
      F3_HU:   ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one valid/ready data-memory request per memory
// instruction, stalls upstream until the response (or timeout), and registers MEM/WB.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_write_in,
  input  logic        mem_read_in,
  input  logic        mem_to_reg_in,
  input  logic [2:0]  funct3_in,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        stall_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  wb_rd_out,
  output logic        wb_reg_write_out,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RSP_TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic        stall;

  logic        mem_op;
  logic        misaligned;
  logic        timeout_hit;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_data;

  lsu_align u_align (
    .acc_funct3  (funct3_in),
    .acc_addr_lo (alu_result_in[1:0]),
    .acc_data    (rs2_data_in),
    .st_wdata    (st_wdata),
    .st_wstrb    (st_wstrb),
    .misaligned  (misaligned),
    .ld_funct3   (funct3_q),
    .ld_addr_lo  (addr_q[1:0]),
    .ld_rdata    (dmem_rsp_rdata),
    .ld_data     (ld_data)
  );

  assign mem_op      = mem_read_in | mem_write_in;
  assign timeout_hit = (RSP_TIMEOUT != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    we_d           = we_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    funct3_d       = funct3_q;
    cnt_d          = cnt_q;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = 1'b0;
    misalign_d     = 1'b0;
    bus_err_d      = 1'b0;
    stall          = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mem_op) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            // A store wins over a load when both flags are set
            addr_d       = alu_result_in;
            wdata_d      = st_wdata;
            wstrb_d      = mem_write_in ? st_wstrb : 4'b0000;
            we_d         = mem_write_in;
            rd_d         = rd_in;
            reg_write_d  = reg_write_in;
            mem_to_reg_d = mem_to_reg_in;
            funct3_d     = funct3_in;
            state_d      = S_REQ;
            stall        = 1'b1;
          end
        end else begin
          wb_data_d      = alu_result_in;
          wb_rd_d        = rd_in;
          wb_reg_write_d = reg_write_in;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        cnt_d = '0;
        if (dmem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d = S_IDLE;
          if (!we_q) begin
            wb_data_d      = mem_to_reg_q ? ld_data : addr_q;
            wb_rd_d        = rd_q;
            wb_reg_write_d = reg_write_q;
          end
        end else if (timeout_hit) begin
          // Release the pipeline on the abort cycle; the instruction is dropped
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      we_q           <= 1'b0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      funct3_q       <= '0;
      cnt_q          <= '0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      we_q           <= we_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      funct3_q       <= funct3_d;
      cnt_q          <= cnt_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      misalign_q     <= misalign_d;
      bus_err_q      <= bus_err_d;
    end
  end

  // Request payload comes only from the latches so it stays stable under backpressure
  assign dmem_req_valid   = (state_q == S_REQ);
  assign dmem_we          = we_q;
  assign dmem_addr        = {addr_q[31:2], 2'b00};
  assign dmem_wdata       = wdata_q;
  assign dmem_wstrb       = wstrb_q;
  assign stall_out        = stall & ~rst;
  assign wb_data_out      = wb_data_q;
  assign wb_rd_out        = wb_rd_q;
  assign wb_reg_write_out = wb_reg_write_q;
  assign misalign_err     = misalign_q;
  assign bus_err          = bus_err_q;

endmodule
